raw2rgb_frame_ctrl: RTL and testbench

Timing controller that sequences the Bayer line-buffer/demosaic datapath from the VGA-domain VS/HS strobes. It generates the pixel/line counters, the registered read window (RD_EN), the per-frame restart pulse for the demosaic pipeline, and Bayer phase bits. It sits between the sensor/VGA timing source and the line buffer plus RAW-to-RGB binning stage, and replaces ad-hoc counter and enable logic with one synchronised state machine.

---
 rtl/raw2rgb_pkg.sv | 25 ++
 rtl/raw2rgb_edge_det.sv | 27 ++
 rtl/raw2rgb_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_raw2rgb_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raw2rgb_pkg.sv
// Shared constants for the RAW-to-RGB frame timing controller.
// Optional build macro: FRAME_STATS_EN (see raw2rgb_frame_ctrl).
package raw2rgb_pkg;

    // FSM encoding, exported on state_o for debug
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_SKIP       = 2'd2;
    localparam logic [1:0] ST_ACTIVE     = 2'd3;

    localparam int unsigned DEF_CNT_W        = 11;
    localparam int unsigned DEF_VAL_LINE_MIN = 1;
    localparam int unsigned DEF_X_MARGIN     = 3;

    // LINE_MAX width and the signed compare width used for the read window
    localparam int unsigned LM_W  = 16;
    localparam int unsigned CMP_W = LM_W + 1;

    // Last pixel index + 1 of the read window; negative when the margin exceeds the line
    function automatic logic signed [CMP_W-1:0] win_limit(input logic [LM_W-1:0] line_max,
                                                         input int unsigned     margin);
        return $signed({1'b0, line_max}) - $signed(CMP_W'(margin));
    endfunction

endpackage

// File: rtl/raw2rgb_edge_det.sv
// Single-register edge detector for the VGA VS/HS strobes.
// Pulses are combinational from the live input and its one-cycle delayed copy.
module raw2rgb_edge_det
    import raw2rgb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic d_q;

    // Delayed copy of the strobe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;
    assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/raw2rgb_frame_ctrl.sv
// Frame timing controller for the Bayer line buffer / demosaic datapath.
// Derives pixel/line counters, the registered read window, a per-frame restart
// pulse and Bayer phase bits from the VGA VS/HS strobes.
// Optional build macro: FRAME_STATS_EN adds frame_cnt and last_lines outputs.
module raw2rgb_frame_ctrl
    import raw2rgb_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned VAL_LINE_MIN = DEF_VAL_LINE_MIN,
    parameter int unsigned X_MARGIN     = DEF_X_MARGIN,
    parameter bit          BAYER_X0     = 1'b0,
    parameter bit          BAYER_Y0     = 1'b0
) (
    input  logic             VGA_CLK,
    input  logic             RST,
    input  logic             VGA_VS,
    input  logic             VGA_HS,
    input  logic [LM_W-1:0]  LINE_MAX,
    output logic [CNT_W-1:0] X_Cont,
    output logic [CNT_W-1:0] Y_Cont,
    output logic             RD_EN,
    output logic             framenew,
    output logic             bayer_x,
    output logic             bayer_y,
    output logic [1:0]       state_o,
    output logic             err_ovf
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic [CNT_W-1:0] last_lines
`endif
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             vs_rise, vs_fall, hs_rise, hs_fall;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [LM_W-1:0]  shadow_q, shadow_d;
    logic             rd_en_q, rd_en_d;
    logic             framenew_q, framenew_d;
    logic             err_ovf_q, err_ovf_d;
    logic             tracking, frame_start, ovf_set;
    logic             x_inc, y_inc;
    logic signed [CMP_W-1:0] x_s, lim_s;

    // Line starts carry no timing information here; only line ends do
    logic unused_hs_rise;
    assign unused_hs_rise = hs_rise;

    raw2rgb_edge_det u_vs_edge (
        .clk_i  (VGA_CLK),
        .rst_i  (RST),
        .d_i    (VGA_VS),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    raw2rgb_edge_det u_hs_edge (
        .clk_i  (VGA_CLK),
        .rst_i  (RST),
        .d_i    (VGA_HS),
        .rise_o (hs_rise),
        .fall_o (hs_fall)
    );

    // Counters only run inside a frame whose start was seen, so a frame
    // interrupted by reset is ignored until the next VS rise.
    assign tracking    = (state_q == ST_SKIP) || (state_q == ST_ACTIVE);
    assign frame_start = (state_q == ST_WAIT_FRAME) && vs_rise;
    assign x_inc       = tracking && VGA_VS && VGA_HS;
    assign y_inc       = tracking && VGA_VS && hs_fall;

    // FSM next state; VS fall overrides every other transition outside IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (!VGA_VS) state_d = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (vs_rise) state_d = ST_SKIP;
            ST_SKIP: begin
                if (hs_fall && (32'(y_q) + 32'd1 > VAL_LINE_MIN)) state_d = ST_ACTIVE;
            end
            ST_ACTIVE:     state_d = ST_ACTIVE;
            default:       state_d = ST_IDLE;
        endcase
        if ((state_q != ST_IDLE) && vs_fall) state_d = ST_WAIT_FRAME;
    end

    // Saturating pixel/line counters and the LINE_MAX shadow capture
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        shadow_d = shadow_q;
        ovf_set  = 1'b0;
        if (frame_start) begin
            x_d      = '0;
            y_d      = '0;
            shadow_d = LINE_MAX;
        end else begin
            if (hs_fall) begin
                x_d = '0;
            end else if (x_inc) begin
                if (x_q == CntMax) ovf_set = 1'b1;
                else               x_d = x_q + CNT_W'(1);
            end
            if (y_inc) begin
                if (y_q == CntMax) ovf_set = 1'b1;
                else               y_d = y_q + CNT_W'(1);
            end
        end
    end

    // Read window, restart pulse and sticky overflow flag
    always_comb begin
        x_s        = $signed(CMP_W'(x_q));
        lim_s      = win_limit(shadow_q, X_MARGIN);
        rd_en_d    = tracking && ((state_q == ST_ACTIVE) || (32'(y_q) > VAL_LINE_MIN)) &&
                     (x_s < lim_s) && VGA_VS && VGA_HS;
        framenew_d = frame_start;
        err_ovf_d  = err_ovf_q;
        if (framenew_q) err_ovf_d = 1'b0;
        if (ovf_set)    err_ovf_d = 1'b1;
    end

    // State register bank
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            shadow_q   <= '0;
            rd_en_q    <= 1'b0;
            framenew_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            shadow_q   <= shadow_d;
            rd_en_q    <= rd_en_d;
            framenew_q <= framenew_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

`ifdef FRAME_STATS_EN
    logic [15:0]      frame_cnt_q;
    logic [CNT_W-1:0] last_lines_q;

    // Frame counter and line count of the last completed frame
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            frame_cnt_q  <= '0;
            last_lines_q <= '0;
        end else begin
            if (framenew_q) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (vs_fall && (state_q != ST_IDLE)) last_lines_q <= y_q;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign last_lines = last_lines_q;
`endif

    assign X_Cont   = x_q;
    assign Y_Cont   = y_q;
    assign RD_EN    = rd_en_q;
    assign framenew = framenew_q;
    assign err_ovf  = err_ovf_q;
    assign state_o  = state_q;
    assign bayer_x  = x_q[0] ^ BAYER_X0;
    assign bayer_y  = y_q[0] ^ BAYER_Y0;

endmodule

// File: tb/tb_raw2rgb_frame_ctrl.sv
// Scoreboard bench for raw2rgb_frame_ctrl: the stimulus pushes expected read
// window pixels and frame starts; a monitor pops them as RD_EN/framenew appear.
module tb_raw2rgb_frame_ctrl;

    localparam int CNT_W    = 11;
    localparam int CNT_MAX  = 2047;
    localparam int LINE_MIN = 1;
    localparam int MARGIN   = 3;

    typedef struct {
        int frame;
        int y;
        int x;
    } exp_t;

    logic             VGA_CLK;
    logic             RST;
    logic             VGA_VS;
    logic             VGA_HS;
    logic [15:0]      LINE_MAX;
    logic [CNT_W-1:0] X_Cont;
    logic [CNT_W-1:0] Y_Cont;
    logic             RD_EN;
    logic             framenew;
    logic             bayer_x;
    logic             bayer_y;
    logic [1:0]       state_o;
    logic             err_ovf;
`ifdef FRAME_STATS_EN
    logic [15:0]      frame_cnt;
    logic [CNT_W-1:0] last_lines;
`endif

    raw2rgb_frame_ctrl #(
        .CNT_W        (CNT_W),
        .VAL_LINE_MIN (LINE_MIN),
        .X_MARGIN     (MARGIN),
        .BAYER_X0     (1'b0),
        .BAYER_Y0     (1'b0)
    ) dut (
        .VGA_CLK  (VGA_CLK),
        .RST      (RST),
        .VGA_VS   (VGA_VS),
        .VGA_HS   (VGA_HS),
        .LINE_MAX (LINE_MAX),
        .X_Cont   (X_Cont),
        .Y_Cont   (Y_Cont),
        .RD_EN    (RD_EN),
        .framenew (framenew),
        .bayer_x  (bayer_x),
        .bayer_y  (bayer_y),
        .state_o  (state_o),
        .err_ovf  (err_ovf)
`ifdef FRAME_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .last_lines (last_lines)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   frames_sent = 0;
    int   mon_frames = 0;
    int   rd_count = 0;
    exp_t exp_q[$];
    int   fn_q[$];

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic vs, input logic hs);
        @(negedge VGA_CLK);
        VGA_VS = vs;
        VGA_HS = hs;
    endtask

    // Monitor: RD_EN at one edge reflects the counters seen one cycle earlier
    int   mon_px = 0;
    int   mon_py = 0;
    exp_t mon_e;
    int   mon_f;
    initial begin
        forever begin
            @(negedge VGA_CLK);
            if (!RST) begin
                if (RD_EN) begin
                    rd_count++;
                    if (exp_q.size() == 0) begin
                        check("rd_unexpected", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("rd_frame", mon_frames - 1, mon_e.frame);
                        check("rd_y", mon_py, mon_e.y);
                        check("rd_x", mon_px, mon_e.x);
                    end
                end
                if (framenew) begin
                    mon_frames++;
                    if (fn_q.size() == 0) begin
                        check("fn_unexpected", 1, 0);
                    end else begin
                        mon_f = fn_q.pop_front();
                        check("fn_index", mon_frames - 1, mon_f);
                        check("fn_x", int'(X_Cont), 0);
                        check("fn_y", int'(Y_Cont), 0);
                    end
                end
            end
            mon_px = int'(X_Cont);
            mon_py = int'(Y_Cont);
        end
    end

    // One frame: VS low gap, VS rise, porch, nlines lines of hslen HS-high cycles.
    // Reference: pixel (y, x) is read iff y > LINE_MIN and x < captured LINE_MAX - MARGIN,
    // with x saturating at CNT_MAX.
    task automatic run_frame(input int lm, input int nlines, input int hslen, input int lm_mid,
                             input bit sat_chk, input bit clash);
        int lim;
        int xx;
        int gap;
        LINE_MAX = 16'(lm);
        repeat (3) tick(1'b0, 1'b0);
        lim = lm - MARGIN;
        fn_q.push_back(frames_sent);
        frames_sent++;
        repeat (4) tick(1'b1, 1'b0);
        check("start_x", int'(X_Cont), 0);
        check("start_y", int'(Y_Cont), 0);
        check("start_ovf", int'(err_ovf), 0);
        check("start_bayer", int'({bayer_y, bayer_x}), 0);
        check("start_state", int'(state_o), 2);
        for (int y = 0; y < nlines; y++) begin
            if (lm_mid >= 0 && y == 1) LINE_MAX = 16'(lm_mid);
            for (int c = 0; c < hslen; c++) begin
                xx = (c > CNT_MAX) ? CNT_MAX : c;
                if (y > LINE_MIN && xx < lim) exp_q.push_back('{frames_sent - 1, y, xx});
                tick(1'b1, 1'b1);
            end
            if (sat_chk) begin
                check("sat_x", int'(X_Cont), CNT_MAX);
                check("sat_ovf", int'(err_ovf), 1);
            end
            gap = int'($urandom_range(2, 4));
            repeat (gap) tick(1'b1, 1'b0);
        end
        check("end_y", int'(Y_Cont), nlines);
        check("end_bayer_y", int'(bayer_y), nlines % 2);
        if (clash) begin
            tick(1'b0, 1'b1);
            @(posedge VGA_CLK);
            #1;
            check("clash_state", int'(state_o), 1);
            check("clash_x", int'(X_Cont), 0);
            check("clash_rd", int'(RD_EN), 0);
        end
        repeat (3) tick(1'b0, 1'b0);
        check("rd_left", exp_q.size(), 0);
        check("fn_left", fn_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lm;
        int nl;
        int hl;
        int mid;
        RST      = 1'b1;
        VGA_VS   = 1'b0;
        VGA_HS   = 1'b0;
        LINE_MAX = 16'd0;
        repeat (3) @(negedge VGA_CLK);
        check("rst_x", int'(X_Cont), 0);
        check("rst_y", int'(Y_Cont), 0);
        check("rst_rd", int'(RD_EN), 0);
        check("rst_fn", int'(framenew), 0);
        check("rst_ovf", int'(err_ovf), 0);
        check("rst_state", int'(state_o), 0);
        @(negedge VGA_CLK);
        RST = 1'b0;

        // Basic 4-line frame: X=0..6 on lines 2 and 3
        base = rd_count;
        run_frame(10, 4, 10, -1, 1'b0, 1'b0);
        check("rd_total_basic", rd_count - base, 14);

        // LINE_MAX change mid-frame only takes effect at the next frame
        base = rd_count;
        run_frame(10, 4, 10, 6, 1'b0, 1'b0);
        check("rd_total_lm_old", rd_count - base, 14);
        base = rd_count;
        run_frame(6, 4, 10, -1, 1'b0, 1'b0);
        check("rd_total_lm_new", rd_count - base, 6);

        // Line shorter than the margin: no window at all
        base = rd_count;
        run_frame(2, 4, 10, -1, 1'b0, 1'b0);
        check("rd_total_short", rd_count - base, 0);

        // X saturation on a long line, then err_ovf clears at the next frame start
        run_frame(10, 1, 2100, -1, 1'b1, 1'b0);
        check("ovf_held", int'(err_ovf), 1);
        run_frame(10, 3, 6, -1, 1'b0, 1'b1);

        // Reset in the middle of a frame; the rest of that frame must be ignored
        LINE_MAX = 16'd10;
        repeat (3) tick(1'b0, 1'b0);
        fn_q.push_back(frames_sent);
        frames_sent++;
        repeat (4) tick(1'b1, 1'b0);
        repeat (10) tick(1'b1, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
        repeat (5) tick(1'b1, 1'b1);
        RST = 1'b1;
        #1;
        check("mid_rst_x", int'(X_Cont), 0);
        check("mid_rst_y", int'(Y_Cont), 0);
        check("mid_rst_rd", int'(RD_EN), 0);
        check("mid_rst_state", int'(state_o), 0);
        repeat (2) tick(1'b1, 1'b1);
        @(negedge VGA_CLK);
        RST = 1'b0;
        repeat (3) tick(1'b1, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
        repeat (2) begin
            repeat (10) tick(1'b1, 1'b1);
            repeat (3) tick(1'b1, 1'b0);
        end
        check("idle_state", int'(state_o), 0);
        check("idle_y", int'(Y_Cont), 0);
        check("idle_x", int'(X_Cont), 0);
        tick(1'b0, 1'b0);

        // Randomized frames against the reference rule
        for (int i = 0; i < 12; i++) begin
            lm  = int'($urandom_range(0, 14));
            nl  = int'($urandom_range(1, 6));
            hl  = int'($urandom_range(1, 14));
            mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 14)) : -1;
            run_frame(lm, nl, hl, mid, 1'b0, $urandom_range(0, 1) == 1);
        end

        repeat (5) tick(1'b0, 1'b0);
        check("final_rd_q", exp_q.size(), 0);
        check("final_fn_q", fn_q.size(), 0);
        check("final_frames", mon_frames, frames_sent);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
